// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies and FSM state encoding.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: signed/unsigned product and
// quotient/remainder, with a flag for division by zero.
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  md_op_e      op,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        signed_div_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] dividend_s;
  logic [31:0] divisor_s;
  logic [31:0] quot_mag_s;
  logic [31:0] rem_mag_s;
  logic [31:0] squot_s;
  logic [31:0] srem_s;
  logic [63:0] sprod_s;
  logic [63:0] uprod_s;

  // Low 64 bits of the sign-extended product are the exact signed product.
  assign sprod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod_s = {32'd0, a} * {32'd0, b};

  // One unsigned divider serves both DIV (on magnitudes) and DIVU.
  assign signed_div_s = (op == MD_DIV);
  assign abs_a_s      = a[31] ? (32'd0 - a) : a;
  assign abs_b_s      = b[31] ? (32'd0 - b) : b;
  assign dividend_s   = signed_div_s ? abs_a_s : a;
  assign divisor_s    = (b == 32'd0) ? 32'd1 : (signed_div_s ? abs_b_s : b);
  assign quot_mag_s   = dividend_s / divisor_s;
  assign rem_mag_s    = dividend_s % divisor_s;

  // 0x80000000 / -1 falls out naturally: magnitude 2^31 re-negates to itself.
  assign squot_s = (a[31] ^ b[31]) ? (32'd0 - quot_mag_s) : quot_mag_s;
  assign srem_s  = a[31] ? (32'd0 - rem_mag_s) : rem_mag_s;

  assign div_zero = op[1] & (b == 32'd0);

  // Select the 64-bit {hi,lo} result for the requested operation.
  always_comb begin
    result = 64'd0;
    case (op)
      MD_MULT:  result = sprod_s;
      MD_MULTU: result = uprod_s;
      MD_DIV:   result = {srem_s, squot_s};
      MD_DIVU:  result = {rem_mag_s, quot_mag_s};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency MULT/DIV sequencing, staging
// of the result and ownership of the architectural HI/LO registers.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  m_or_d,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HI_write,
  input  logic        LO_write,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES - 1);

  md_state_e   state_r;
  md_state_e   next_state_s;
  logic [3:0]  cnt_r;
  logic [63:0] stage_r;
  logic        stage_dz_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic [63:0] arith_result_s;
  logic        arith_dz_s;
  logic        load_s;
  logic        commit_s;
  logic        mthi_s;
  logic        mtlo_s;

  md_arith u_arith (
    .a        (A),
    .b        (B),
    .op       (md_op_e'(m_or_d)),
    .result   (arith_result_s),
    .div_zero (arith_dz_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = start ? RUN : IDLE;
      RUN:     next_state_s = (cnt_r == 4'd0) ? IDLE : RUN;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs; start wins over MTHI/MTLO, and everything is ignored in RUN.
  always_comb begin
    load_s   = 1'b0;
    commit_s = 1'b0;
    mthi_s   = 1'b0;
    mtlo_s   = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = start;
        mthi_s = HI_write & ~start;
        mtlo_s = LO_write & ~start;
      end
      RUN:     commit_s = (cnt_r == 4'd0);
      default: load_s   = 1'b0;
    endcase
  end

  // Latency counter, staging registers and registered busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= 4'd0;
      stage_r    <= 64'd0;
      stage_dz_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      busy_r <= (next_state_s == RUN);
      if (load_s) begin
        stage_r    <= arith_result_s;
        stage_dz_r <= arith_dz_s;
        cnt_r      <= m_or_d[1] ? DIV_CNT : MULT_CNT;
      end else if ((state_r == RUN) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Architectural HI/LO: result commit or MTHI/MTLO writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (commit_s) begin
      if (!stage_dz_r) begin
        hi_r <= stage_r[63:32];
        lo_r <= stage_r[31:0];
      end
    end else begin
      if (mthi_s) hi_r <= A;
      if (mtlo_s) lo_r <= A;
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected {HI,LO,latency},
// a monitor pops and compares whenever busy falls.
module tb_md_unit;
  import md_pkg::*;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b1;
  logic        start    = 1'b0;
  logic [1:0]  m_or_d   = 2'b00;
  logic [31:0] A        = 32'd0;
  logic [31:0] B        = 32'd0;
  logic        HI_write = 1'b0;
  logic        LO_write = 1'b0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .m_or_d   (m_or_d),
    .A        (A),
    .B        (B),
    .HI_write (HI_write),
    .LO_write (LO_write),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  bit          abort_pending = 1'b0;
  bit          busy_prev     = 1'b0;
  int          run_cnt       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles, compare against the scoreboard when busy falls.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      run_cnt++;
    end else if (busy_prev) begin
      if (abort_pending) begin
        abort_pending = 1'b0;
      end else if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit: got HI=%08h LO=%08h expected no commit", HI, LO);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, HI, e.hi);
        chk({e.name, "_lo"}, LO, e.lo);
        chk({e.name, "_cycles"}, 32'(run_cnt), 32'(e.cyc));
      end
      run_cnt = 0;
    end
    busy_prev = (busy === 1'b1);
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got busy=1 expected busy=0 within 40 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_op(input string name, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int cyc,
                        input logic hw, input logic lw);
    sb.push_back('{exp_hi, exp_lo, cyc, name});
    @(posedge clk); #1;
    start = 1'b1; m_or_d = op; A = a; B = b; HI_write = hw; LO_write = lw;
    @(posedge clk); #1;
    start = 1'b0; HI_write = 1'b0; LO_write = 1'b0;
    wait_idle(name);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  task automatic mt(input string name, input logic hw, input logic lw, input logic [31:0] a);
    @(posedge clk); #1;
    HI_write = hw; LO_write = lw; A = a;
    @(posedge clk); #1;
    HI_write = 1'b0; LO_write = 1'b0;
    if (hw) m_hi = a;
    if (lw) m_lo = a;
    chk({name, "_hi"}, HI, m_hi);
    chk({name, "_lo"}, LO, m_lo);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset_n = 1'b1;

    run_op("mult_neg",   MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  1'b0, 1'b0);
    run_op("multu_max",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5,  1'b0, 1'b0);
    run_op("mult_min",   MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5,  1'b0, 1'b0);
    run_op("div_neg",    MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0, 1'b0);
    run_op("divu",       MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10, 1'b0, 1'b0);
    run_op("div_negb",   MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, 1'b0, 1'b0);
    run_op("div_ovf",    MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, 1'b0, 1'b0);

    mt("mthi", 1'b1, 1'b0, 32'h00001234);
    run_op("div_zero",   MD_DIV,   32'h55555555, 32'd0,        32'h00001234, 32'h80000000, 10, 1'b0, 1'b0);
    mt("mthi_mtlo", 1'b1, 1'b1, 32'hCAFEF00D);
    // start with MTHI/MTLO in the same cycle: writes dropped, div-by-zero keeps HI/LO.
    run_op("start_prio", MD_DIVU,  32'h00000009, 32'd0,        32'hCAFEF00D, 32'hCAFEF00D, 10, 1'b1, 1'b1);

    // Mid-run start/MTHI/MTLO must be ignored; MULT 6*7 commits on schedule.
    sb.push_back('{32'h00000000, 32'd42, 5, "midrun"});
    @(posedge clk); #1;
    start = 1'b1; m_or_d = MD_MULT; A = 32'd6; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; m_or_d = MD_DIV; A = 32'hDEADBEEF; B = 32'd1; HI_write = 1'b1; LO_write = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0; HI_write = 1'b0; LO_write = 1'b0;
    wait_idle("midrun");
    m_hi = 32'd0; m_lo = 32'd42;

    // Reset in the middle of a DIV discards it.
    @(posedge clk); #1;
    start = 1'b1; m_or_d = MD_DIV; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    abort_pending = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #3;
    reset_n = 1'b1;
    mt("mtlo_after_reset", 1'b0, 1'b1, 32'd5);
    repeat (12) begin @(posedge clk); #1; end
    chk("no_commit_after_reset", {31'd0, busy}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
